micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Parametrised microprogram sequencer that generates the control-store address (`mpc`) for the microcoded processor. It replaces the fixed-step instruction counter: on each clock it executes the sequencing opcode returned by the control ROM at the current address. Opcodes cover next, jump, conditional branch on a status flag, subroutine call/return with a hardware stack, opcode dispatch from the instruction register, and end-of-routine return to the fetch routine. It sits between the instruction register/status flags and the microcode ROM.

## Interface
Parameters:
- `ADDR_W`, 6, control-store address width
- `STACK_DEPTH`, 4, return-stack entries (≥1)
- `NUM_FLAGS`, 4, status flags selectable by BRANCH (≥2, power of 2)
- `FETCH_ADDR`, 0, address of the fetch microroutine

Ports (`SW = $clog2(STACK_DEPTH+1)`, `FW = $clog2(NUM_FLAGS)`):
- `clk` in 1 — single clock, all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — leave IDLE and begin at `FETCH_ADDR`
- `hold` in 1 — stall; all state frozen while high
- `op` in 3 — sequencing opcode from ROM word at current `mpc`
- `target` in ADDR_W — jump/branch/call target from ROM word
- `cond_sel` in FW — flag index for BRANCH
- `cond_inv` in 1 — invert selected flag for BRANCH
- `flags` in NUM_FLAGS — status flags (Z, C, N, ...)
- `dispatch_addr` in ADDR_W — routine start address decoded from IR
- `mpc` out ADDR_W — current control-store address (registered)
- `running` out 1 — high in RUN state
- `done` out 1 — one-cycle pulse after an END executes
- `sp` out SW — current stack occupancy
- `err_ovf` out 1 — sticky: CALL with full stack
- `err_udf` out 1 — sticky: RET with empty stack

## Operation
- States: IDLE, RUN, FAULT.
- IDLE: `mpc` holds, `op` ignored; `start`=1 → `mpc`←FETCH_ADDR, RUN.
- RUN, per non-held cycle, decode `op`:
  - 0 NEXT: `mpc`←`mpc`+1, modulo 2^ADDR_W (all-ones wraps to 0)
  - 1 JUMP: `mpc`←`target`
  - 2 BRANCH: taken iff `flags[cond_sel]`^`cond_inv`=1 → `target`, else `mpc`+1
  - 3 CALL: push `mpc`+1 (wrapped), `mpc`←`target`, `sp`+1
  - 4 RET: `mpc`←top of stack, `sp`−1
  - 5 DISPATCH: `mpc`←`dispatch_addr`
  - 6 END: `mpc`←FETCH_ADDR, stack cleared (`sp`←0, no error), `done`←1 next cycle
  - 7 STOP: `mpc` holds, → IDLE
- CALL with `sp`=STACK_DEPTH: no push, `mpc` holds, `err_ovf`←1, → FAULT.
- RET with `sp`=0: `mpc` holds, `err_udf`←1, → FAULT.
- FAULT: everything frozen; `start` ignored; only `rst` exits.
- `start` ignored outside IDLE.
- Stack is LIFO; unused entries are don't-care and not observable.

## Timing
- Reset values: `mpc`=FETCH_ADDR, state IDLE, `running`=0, `done`=0, `sp`=0, `err_ovf`=0, `err_udf`=0.
- `rst` has priority over `hold`, `start` and `op`; reset mid-routine discards stack and errors in the same edge.
- `hold` has priority over everything except `rst`: `mpc`, `sp`, state, stack frozen; `done` forced 0 while held.
- `op`/`target`/`cond_*` are combinational functions of current `mpc` (async ROM) and are sampled at the same edge that updates `mpc`: one-cycle latency per microinstruction, no bubbles.
- `flags` and `dispatch_addr` sampled at the executing edge.
- `running` is registered, high the cycle after `start` is accepted through the cycle a STOP/fault is taken.
- `done` high exactly one cycle, the cycle `mpc` first shows FETCH_ADDR after END.
- `sp` updates on the same edge as the CALL/RET `mpc` change.

## Test plan
- Reset/start: `rst`=1 two cycles → `mpc`=0, `sp`=0, `running`=0; `start`=1 one cycle → `running`=1 next cycle, `mpc`=0; NEXT ×3 → `mpc` 1,2,3.
- Dispatch/end: at `mpc`=3 DISPATCH with `dispatch_addr`=21, then NEXT, NEXT, END → `mpc` 21,22,23,0; `done` pulses once with `mpc`=0.
- Branch: `flags`=4'b0001, BRANCH `cond_sel`=0 `target`=40 → `mpc`=40; same with `cond_inv`=1 at `mpc`=40 → `mpc`=41.
- Call/return + wrap: CALL 50 at `mpc`=10 → `mpc`=50, `sp`=1; CALL 60 → `sp`=2; RET → 51; RET → 11, `sp`=0; NEXT at 63 → 0.
- Overflow/underflow: 5 nested CALLs (depth 4) → 5th leaves `mpc` unchanged, `err_ovf`=1, `running`=0, `start` ignored; `rst` clears; RET at `sp`=0 → `err_udf`=1.
- Hold and reset mid-routine: `hold`=1 three cycles during NEXT sequence at `mpc`=22 → `mpc`,`sp` stay 22/1; `rst` with `hold`=1 and `sp`=2 → `mpc`=0, `sp`=0, IDLE.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer
// ---------------
// Microprogram sequencer: produces the control-store address (mpc) for the
// microcoded processor. Each cycle in RUN it executes the sequencing opcode
// that the (asynchronous) control ROM returns for the current mpc. The
// opcodes are next, jump, conditional branch, call/return on a hardware
// stack, dispatch from the instruction register, end-of-routine and stop.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset (highest priority)
//   start         leave IDLE and begin at FETCH_ADDR (ignored elsewhere)
//   hold          stall; freezes mpc, sp, state and stack, forces done low
//   op            sequencing opcode from the ROM word at mpc
//   target        jump/branch/call target from the ROM word
//   cond_sel      flag index for BRANCH
//   cond_inv      invert the selected flag for BRANCH
//   flags         status flags
//   dispatch_addr routine start address decoded from the IR
//   mpc           current control-store address (registered)
//   running       high while in RUN
//   done          one-cycle pulse, the cycle mpc first shows FETCH_ADDR after END
//   sp            return-stack occupancy
//   err_ovf       sticky: CALL attempted with a full stack
//   err_udf       sticky: RET attempted with an empty stack
module micro_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned NUM_FLAGS   = 4,
  parameter int unsigned FETCH_ADDR  = 0,
  localparam int unsigned SW = $clog2(STACK_DEPTH + 1),
  localparam int unsigned FW = $clog2(NUM_FLAGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic [FW-1:0]     cond_sel,
  input  logic              cond_inv,
  input  logic [NUM_FLAGS-1:0] flags,
  input  logic [ADDR_W-1:0] dispatch_addr,
  output logic [ADDR_W-1:0] mpc,
  output logic              running,
  output logic              done,
  output logic [SW-1:0]     sp,
  output logic              err_ovf,
  output logic              err_udf
);

  // Stack index width; a depth of one still needs a one-bit index.
  localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] FETCH    = ADDR_W'(FETCH_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [SW-1:0]     SP_ONE   = SW'(1);
  localparam logic [SW-1:0]     SP_FULL  = SW'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NEXT     = 3'd0,
    OP_JUMP     = 3'd1,
    OP_BRANCH   = 3'd2,
    OP_CALL     = 3'd3,
    OP_RET      = 3'd4,
    OP_DISPATCH = 3'd5,
    OP_END      = 3'd6,
    OP_STOP     = 3'd7
  } op_t;

  state_t            state;
  state_t            nxt_state;
  op_t               opc;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] mpc_inc;
  logic [ADDR_W-1:0] nxt_mpc;
  logic [SW-1:0]     nxt_sp;
  logic [IW-1:0]     push_idx;
  logic [IW-1:0]     pop_idx;
  logic              push;
  logic              set_ovf;
  logic              set_udf;
  logic              end_exec;
  logic              taken;

  assign opc      = op_t'(op);
  // Natural wrap of the ADDR_W-bit adder gives the modulo-2^ADDR_W step.
  assign mpc_inc  = mpc + ADDR_ONE;
  assign taken    = flags[cond_sel] ^ cond_inv;
  assign push_idx = IW'(sp);
  assign pop_idx  = IW'(sp - SP_ONE);

  // Next-state decode; only consumed on non-held, non-reset edges.
  always_comb begin
    nxt_state = state;
    nxt_mpc   = mpc;
    nxt_sp    = sp;
    push      = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    end_exec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_mpc   = FETCH;
          nxt_state = S_RUN;
        end
      end
      S_RUN: begin
        case (opc)
          OP_NEXT:     nxt_mpc = mpc_inc;
          OP_JUMP:     nxt_mpc = target;
          OP_BRANCH:   nxt_mpc = taken ? target : mpc_inc;
          OP_CALL: begin
            if (sp == SP_FULL) begin
              set_ovf   = 1'b1;
              nxt_state = S_FAULT;
            end else begin
              push    = 1'b1;
              nxt_mpc = target;
              nxt_sp  = sp + SP_ONE;
            end
          end
          OP_RET: begin
            if (sp == '0) begin
              set_udf   = 1'b1;
              nxt_state = S_FAULT;
            end else begin
              nxt_mpc = stack[pop_idx];
              nxt_sp  = sp - SP_ONE;
            end
          end
          OP_DISPATCH: nxt_mpc = dispatch_addr;
          OP_END: begin
            nxt_mpc  = FETCH;
            nxt_sp   = '0;
            end_exec = 1'b1;
          end
          OP_STOP:     nxt_state = S_IDLE;
        endcase
      end
      default: ; // S_FAULT: frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mpc     <= FETCH;
      sp      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else if (hold) begin
      done <= 1'b0;
    end else begin
      state   <= nxt_state;
      mpc     <= nxt_mpc;
      sp      <= nxt_sp;
      running <= (nxt_state == S_RUN);
      done    <= end_exec;
      err_ovf <= err_ovf | set_ovf;
      err_udf <= err_udf | set_udf;
    end
  end

  // Stack storage carries no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (!rst && !hold && push) begin
      stack[push_idx] <= mpc_inc;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer (default parameters: ADDR_W=6, depth 4,
// 4 flags, fetch at 0). Directed vector table, hand-written overflow
// sequence, then random stimulus against a queue-based reference model.
module tb_micro_sequencer;

  localparam int NXT = 0, JMP = 1, BRA = 2, CAL = 3, RET = 4, DSP = 5, ENDOP = 6, STP = 7;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, start, hold, cond_inv;
  logic [2:0] op;
  logic [5:0] target, dispatch_addr;
  logic [1:0] cond_sel;
  logic [3:0] flags;
  logic [5:0] mpc;
  logic       running, done, err_ovf, err_udf;
  logic [2:0] sp;

  int n_cmp = 0;
  int n_err = 0;

  micro_sequencer #(
    .ADDR_W(6), .STACK_DEPTH(4), .NUM_FLAGS(4), .FETCH_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .op(op),
    .target(target), .cond_sel(cond_sel), .cond_inv(cond_inv),
    .flags(flags), .dispatch_addr(dispatch_addr), .mpc(mpc),
    .running(running), .done(done), .sp(sp),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rst, hold, start;
    int        op, tgt, csel;
    bit        cinv;
    int        flg, disp;
    int        e_mpc;
    bit        e_run, e_done;
    int        e_sp;
    bit        e_ovf, e_udf;
    string     nm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, h, s, input int o, t, cs, input bit ci,
                     input int fl, dp, em, input bit er, ed, input int es,
                     input bit eo, eu, input string nm);
    vec_t v;
    v = '{r, h, s, o, t, cs, ci, fl, dp, em, er, ed, es, eo, eu, nm};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive away from the active edge, sample 1 time unit after it.
  task automatic drive(input bit r, h, s, input int o, t, cs, input bit ci,
                       input int fl, dp);
    @(negedge clk);
    rst = r; hold = h; start = s; op = 3'(o); target = 6'(t);
    cond_sel = 2'(cs); cond_inv = ci; flags = 4'(fl); dispatch_addr = 6'(dp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input int em, input bit er, ed,
                           input int es, input bit eo, eu);
    chk({nm, ".mpc"}, int'(mpc), em);
    chk({nm, ".running"}, int'(running), int'(er));
    chk({nm, ".done"}, int'(done), int'(ed));
    chk({nm, ".sp"}, int'(sp), es);
    chk({nm, ".err_ovf"}, int'(err_ovf), int'(eo));
    chk({nm, ".err_udf"}, int'(err_udf), int'(eu));
  endtask

  // Reference model: abstract mode plus a queue for the return stack.
  typedef enum {M_IDLE, M_RUN, M_FAULT} mode_t;
  mode_t m_mode;
  int    m_mpc;
  int    m_stk[$];
  bit    m_done, m_ovf, m_udf;

  task automatic model_edge(input bit r, h, s, input int o, t, cs, input bit ci,
                            input int fl, dp);
    bit f;
    if (r) begin
      m_mode = M_IDLE; m_mpc = 0; m_stk.delete();
      m_done = 0; m_ovf = 0; m_udf = 0;
      return;
    end
    m_done = 0;
    if (h) return;
    if (m_mode == M_IDLE) begin
      if (s) begin m_mpc = 0; m_mode = M_RUN; end
    end else if (m_mode == M_RUN) begin
      case (o)
        NXT: m_mpc = (m_mpc + 1) % 64;
        JMP: m_mpc = t;
        BRA: begin
          f = ((fl >> cs) & 1) != 0;
          m_mpc = (f != ci) ? t : (m_mpc + 1) % 64;
        end
        CAL: begin
          if (m_stk.size() == DEPTH) begin m_ovf = 1; m_mode = M_FAULT; end
          else begin m_stk.push_back((m_mpc + 1) % 64); m_mpc = t; end
        end
        RET: begin
          if (m_stk.size() == 0) begin m_udf = 1; m_mode = M_FAULT; end
          else m_mpc = m_stk.pop_back();
        end
        DSP: m_mpc = dp;
        ENDOP: begin m_mpc = 0; m_stk.delete(); m_done = 1; end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  initial begin
    rst = 1; hold = 0; start = 0; op = '0; target = '0; cond_sel = '0;
    cond_inv = 0; flags = '0; dispatch_addr = '0;

    //   rst h s  op    tgt cs ci flg  disp  mpc run done sp ovf udf
    add(1, 0, 0, NXT,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 0, "reset1");
    add(1, 0, 0, NXT,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 0, "reset2");
    add(0, 0, 1, NXT,   0, 0, 0, 0,   0,    0, 1, 0, 0, 0, 0, "start");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,    1, 1, 0, 0, 0, 0, "next1");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,    2, 1, 0, 0, 0, 0, "next2");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,    3, 1, 0, 0, 0, 0, "next3");
    add(0, 0, 0, DSP,   0, 0, 0, 0,  21,   21, 1, 0, 0, 0, 0, "dispatch");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,   22, 1, 0, 0, 0, 0, "disp_next1");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,   23, 1, 0, 0, 0, 0, "disp_next2");
    add(0, 0, 0, ENDOP, 0, 0, 0, 0,   0,    0, 1, 1, 0, 0, 0, "end");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,    1, 1, 0, 0, 0, 0, "after_end");
    add(0, 0, 0, BRA,  40, 0, 0, 1,   0,   40, 1, 0, 0, 0, 0, "br_taken");
    add(0, 0, 0, BRA,  40, 0, 1, 1,   0,   41, 1, 0, 0, 0, 0, "br_inv_not_taken");
    add(0, 0, 0, BRA,  10, 2, 0, 4,   0,   10, 1, 0, 0, 0, 0, "br_flag2");
    add(0, 0, 0, CAL,  50, 0, 0, 0,   0,   50, 1, 0, 1, 0, 0, "call50");
    add(0, 0, 0, CAL,  60, 0, 0, 0,   0,   60, 1, 0, 2, 0, 0, "call60");
    add(0, 0, 0, RET,   0, 0, 0, 0,   0,   51, 1, 0, 1, 0, 0, "ret1");
    add(0, 0, 0, RET,   0, 0, 0, 0,   0,   11, 1, 0, 0, 0, 0, "ret2");
    add(0, 0, 0, BRA,  33, 1, 0, 13,  0,   12, 1, 0, 0, 0, 0, "br_not_taken");
    add(0, 0, 0, JMP,  63, 0, 0, 0,   0,   63, 1, 0, 0, 0, 0, "jump63");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,    0, 1, 0, 0, 0, 0, "next_wrap");
    add(0, 0, 0, CAL,  63, 0, 0, 0,   0,   63, 1, 0, 1, 0, 0, "call63");
    add(0, 0, 0, CAL,   5, 0, 0, 0,   0,    5, 1, 0, 2, 0, 0, "call_at_top");
    add(0, 0, 0, RET,   0, 0, 0, 0,   0,    0, 1, 0, 1, 0, 0, "ret_wrapped");
    add(0, 0, 0, RET,   0, 0, 0, 0,   0,    1, 1, 0, 0, 0, 0, "ret_to_1");
    add(0, 0, 0, STP,   0, 0, 0, 0,   0,    1, 0, 0, 0, 0, 0, "stop");
    add(0, 0, 0, JMP,  30, 0, 0, 0,   0,    1, 0, 0, 0, 0, 0, "idle_ignores_op");
    add(0, 0, 1, JMP,  30, 0, 0, 0,   0,    0, 1, 0, 0, 0, 0, "restart");
    add(0, 0, 1, NXT,   0, 0, 0, 0,   0,    1, 1, 0, 0, 0, 0, "start_in_run");
    add(0, 0, 0, CAL,  20, 0, 0, 0,   0,   20, 1, 0, 1, 0, 0, "call20");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,   21, 1, 0, 1, 0, 0, "n21");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,   22, 1, 0, 1, 0, 0, "n22");
    add(0, 1, 0, NXT,   0, 0, 0, 0,   0,   22, 1, 0, 1, 0, 0, "hold1");
    add(0, 1, 0, NXT,   0, 0, 0, 0,   0,   22, 1, 0, 1, 0, 0, "hold2");
    add(0, 1, 0, RET,   0, 0, 0, 0,   0,   22, 1, 0, 1, 0, 0, "hold3");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,   23, 1, 0, 1, 0, 0, "after_hold");
    add(0, 1, 0, ENDOP, 0, 0, 0, 0,   0,   23, 1, 0, 1, 0, 0, "end_held");
    add(0, 0, 0, ENDOP, 0, 0, 0, 0,   0,    0, 1, 1, 0, 0, 0, "end_clears_sp");
    add(0, 0, 0, CAL,  40, 0, 0, 0,   0,   40, 1, 0, 1, 0, 0, "call40");
    add(0, 0, 0, CAL,  41, 0, 0, 0,   0,   41, 1, 0, 2, 0, 0, "call41");
    add(1, 1, 0, NXT,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 0, "rst_over_hold");
    add(0, 0, 1, NXT,   0, 0, 0, 0,   0,    0, 1, 0, 0, 0, 0, "start_udf");
    add(0, 0, 0, RET,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 1, "ret_underflow");
    add(0, 0, 1, NXT,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 1, "fault_ignores_start");
    add(0, 0, 0, NXT,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 1, "fault_frozen");
    add(1, 0, 0, NXT,   0, 0, 0, 0,   0,    0, 0, 0, 0, 0, 0, "rst_clears_udf");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].hold, vecs[i].start, vecs[i].op, vecs[i].tgt,
            vecs[i].csel, vecs[i].cinv, vecs[i].flg, vecs[i].disp);
      check_all(vecs[i].nm, vecs[i].e_mpc, vecs[i].e_run, vecs[i].e_done,
                vecs[i].e_sp, vecs[i].e_ovf, vecs[i].e_udf);
    end

    // Overflow: four nested calls fill the stack, the fifth faults in place.
    drive(0, 0, 1, NXT, 0, 0, 0, 0, 0);
    check_all("ovf_start", 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, CAL, i * 10, 0, 0, 0, 0);
      check_all("ovf_call", i * 10, 1, 0, i, 0, 0);
    end
    drive(0, 0, 0, CAL, 50, 0, 0, 0, 0);
    check_all("ovf_fifth", 40, 0, 0, 4, 1, 0);
    drive(0, 0, 1, NXT, 0, 0, 0, 0, 0);
    check_all("ovf_start_ignored", 40, 0, 0, 4, 1, 0);
    drive(1, 0, 0, NXT, 0, 0, 0, 0, 0);
    check_all("ovf_rst", 0, 0, 0, 0, 0, 0);

    // Random stimulus against the reference model.
    model_edge(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, h, s, ci;
      int o, t, cs, fl, dp;
      r  = ($urandom_range(0, 39) == 0);
      h  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      o  = $urandom_range(0, 7);
      if (o == STP && $urandom_range(0, 1) == 0) o = NXT;
      t  = $urandom_range(0, 63);
      cs = $urandom_range(0, 3);
      ci = 1'($urandom_range(0, 1));
      fl = $urandom_range(0, 15);
      dp = $urandom_range(0, 63);
      drive(r, h, s, o, t, cs, ci, fl, dp);
      model_edge(r, h, s, o, t, cs, ci, fl, dp);
      check_all("rand", m_mpc, m_mode == M_RUN, m_done, m_stk.size(), m_ovf, m_udf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
